pipe_hazard_ctrl: RTL and testbench

Parametrised ID-stage control unit for the 5-stage pipeline: decodes the instruction in ID, tracks the destination and write class of the instructions in EX and MEM in its own shadow registers, drives operand-forwarding selects, and detects load-use hazards, stalling IF/ID and injecting a bubble into EX. It replaces the combinational decoder/forwarder and fixes its forwarding priority: the newest producer wins. Register 0 is never forwarded, and unknown opcodes decode to a safe no-op.

---
 rtl/pipe_hazard_ctrl_if.sv | 35 +++
 rtl/pipe_hazard_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage control bundle: instruction fields into the hazard unit,
// decode/forward/stall controls back out to the datapath.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);
  logic [5:0]        op;
  logic [5:0]        func;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic              wreg;
  logic              m2reg;
  logic              wmem;
  logic [3:0]        aluc;
  logic              aluimm;
  logic              regrt;
  logic [1:0]        fwda;
  logic [1:0]        fwdb;
  logic              wpcir;
  logic              illegal;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output op, func, rs, rt, rd,
    input  wreg, m2reg, wmem, aluc, aluimm, regrt,
           fwda, fwdb, wpcir, illegal, stall_cnt
  );

  modport slave (
    input  op, func, rs, rt, rd,
    output wreg, m2reg, wmem, aluc, aluimm, regrt,
           fwda, fwdb, wpcir, illegal, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ID-stage decoder, forwarding select and load-use stall unit.
// Define PIPE_HAZARD_FWD_EN for forwarding; otherwise dependents stall until WB.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input logic               clk,
  input logic               clrn,
  pipe_hazard_ctrl_if.slave id
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic              dec_wreg, dec_m2reg, dec_wmem, dec_aluimm, dec_regrt, dec_illegal;
  logic [3:0]        dec_aluc;
  logic              use_rs, use_rt;
  logic [REG_AW-1:0] idest;
  logic              stall;
  logic              wreg_g, wmem_g, m2reg_g;

  logic              ewreg_q, ewreg_d;
  logic [REG_AW-1:0] edest_q, edest_d;
  logic              mwreg_q, mwreg_d;
  logic [REG_AW-1:0] mdest_q, mdest_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    dec_wreg    = 1'b0;
    dec_m2reg   = 1'b0;
    dec_wmem    = 1'b0;
    dec_aluc    = 4'b0000;
    dec_aluimm  = 1'b0;
    dec_regrt   = 1'b0;
    dec_illegal = 1'b0;
    unique case (id.op)
      OP_RTYPE: begin
        dec_wreg = 1'b1;
        unique case (id.func)
          6'b100000: dec_aluc = 4'b0010;
          6'b100010: dec_aluc = 4'b0110;
          6'b100100: dec_aluc = 4'b0000;
          6'b100101: dec_aluc = 4'b0001;
          6'b100110: dec_aluc = 4'b1001;
          6'b101010: dec_aluc = 4'b0111;
          default: begin
            dec_wreg    = 1'b0;
            dec_illegal = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        dec_wreg   = 1'b1;
        dec_m2reg  = 1'b1;
        dec_aluc   = 4'b0010;
        dec_aluimm = 1'b1;
        dec_regrt  = 1'b1;
      end
      OP_SW: begin
        dec_wmem   = 1'b1;
        dec_aluc   = 4'b0010;
        dec_aluimm = 1'b1;
        dec_regrt  = 1'b1;
      end
      OP_ADDI: begin
        dec_wreg   = 1'b1;
        dec_aluc   = 4'b0010;
        dec_aluimm = 1'b1;
        dec_regrt  = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign use_rs = !dec_illegal;
  assign use_rt = !dec_illegal && ((id.op == OP_RTYPE) || (id.op == OP_SW));
  assign idest  = dec_regrt ? id.rt : id.rd;

  // A producer hits a source only if it writes, is not r0, and the source is read.
  function automatic logic hits(input logic wr, input logic [REG_AW-1:0] dst,
                                input logic ua, input logic [REG_AW-1:0] sa,
                                input logic ub, input logic [REG_AW-1:0] sb);
    return wr && (dst != '0) && ((ua && dst == sa) || (ub && dst == sb));
  endfunction

`ifdef PIPE_HAZARD_FWD_EN
  logic em2reg_q, em2reg_d;
  logic mm2reg_q, mm2reg_d;

  // EX is checked first so the newest producer wins; loads in EX are never forwarded.
  function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_AW-1:0] s,
                                         input logic ew, input logic em, input logic [REG_AW-1:0] ed,
                                         input logic mw, input logic mm, input logic [REG_AW-1:0] md);
    logic [1:0] sel;
    sel = 2'b00;
    if (used && s != '0) begin
      if (ew && ed == s && !em)  sel = 2'b01;
      else if (mw && md == s)    sel = mm ? 2'b11 : 2'b10;
    end
    return sel;
  endfunction

  assign stall = em2reg_q && hits(ewreg_q, edest_q, use_rs, id.rs, use_rt, id.rt);

  always_comb begin
    id.fwda = 2'b00;
    id.fwdb = 2'b00;
    if (!stall) begin
      id.fwda = fwd_sel(use_rs, id.rs, ewreg_q, em2reg_q, edest_q, mwreg_q, mm2reg_q, mdest_q);
      id.fwdb = fwd_sel(use_rt, id.rt, ewreg_q, em2reg_q, edest_q, mwreg_q, mm2reg_q, mdest_q);
    end
  end

  assign em2reg_d = m2reg_g;
  assign mm2reg_d = em2reg_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      em2reg_q <= 1'b0;
      mm2reg_q <= 1'b0;
    end else begin
      em2reg_q <= em2reg_d;
      mm2reg_q <= mm2reg_d;
    end
  end
`else
  assign stall = hits(ewreg_q, edest_q, use_rs, id.rs, use_rt, id.rt) ||
                 hits(mwreg_q, mdest_q, use_rs, id.rs, use_rt, id.rt);
  assign id.fwda = 2'b00;
  assign id.fwdb = 2'b00;
`endif

  assign wreg_g  = dec_wreg  && !stall;
  assign wmem_g  = dec_wmem  && !stall;
  assign m2reg_g = dec_m2reg && !stall;

  assign ewreg_d = wreg_g;
  assign edest_d = idest;
  assign mwreg_d = ewreg_q;
  assign mdest_d = edest_q;
  assign cnt_d   = (stall && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ewreg_q <= 1'b0;
      edest_q <= '0;
      mwreg_q <= 1'b0;
      mdest_q <= '0;
      cnt_q   <= '0;
    end else begin
      ewreg_q <= ewreg_d;
      edest_q <= edest_d;
      mwreg_q <= mwreg_d;
      mdest_q <= mdest_d;
      cnt_q   <= cnt_d;
    end
  end

  assign id.wreg      = wreg_g;
  assign id.wmem      = wmem_g;
  assign id.m2reg     = dec_m2reg;
  assign id.aluc      = dec_aluc;
  assign id.aluimm    = dec_aluimm;
  assign id.regrt     = dec_regrt;
  assign id.illegal   = dec_illegal;
  assign id.wpcir     = !stall;
  assign id.stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; covers whichever forwarding build is compiled.
module tb_pipe_hazard_ctrl;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 16;

  logic clk = 1'b0;
  logic clrn;
  int   n_tests = 0;
  int   n_fail  = 0;

  pipe_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) id_if ();

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .clrn (clrn),
    .id   (id_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rtype(input logic [5:0] fn, input int rd, input int rs, input int rt);
    id_if.op   = 6'b000000;
    id_if.func = fn;
    id_if.rd   = REG_AW'(rd);
    id_if.rs   = REG_AW'(rs);
    id_if.rt   = REG_AW'(rt);
    #1;
  endtask

  task automatic itype(input logic [5:0] opc, input int rt, input int rs);
    id_if.op   = opc;
    id_if.func = 6'b000000;
    id_if.rd   = '0;
    id_if.rs   = REG_AW'(rs);
    id_if.rt   = REG_AW'(rt);
    #1;
  endtask

  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101, F_XOR = 6'b100110;
  localparam logic [5:0] O_LW  = 6'b100011, O_SW  = 6'b101011, O_ADDI = 6'b001000;

  initial begin
    clrn = 1'b0;
    itype(6'b111111, 1, 1);
    check("rst_illegal", 32'(id_if.illegal), 32'd1);
    check("rst_wreg",    32'(id_if.wreg),    32'd0);
    check("rst_wpcir",   32'(id_if.wpcir),   32'd1);
    check("rst_cnt",     32'(id_if.stall_cnt), 32'd0);
    rtype(F_ADD, 3, 1, 2);
    check("rst_fwda",    32'(id_if.fwda),    32'd0);
    check("add_aluc",    32'(id_if.aluc),    32'h2);
    tick();
    clrn = 1'b1;
    tick();

`ifdef PIPE_HAZARD_FWD_EN
    rtype(F_ADD, 3, 1, 2);
    check("add_wreg", 32'(id_if.wreg), 32'd1);
    tick();
    rtype(F_SUB, 4, 3, 1);
    check("ex_fwda",  32'(id_if.fwda),  32'd1);
    check("ex_fwdb",  32'(id_if.fwdb),  32'd0);
    check("ex_wpcir", 32'(id_if.wpcir), 32'd1);
    check("sub_aluc", 32'(id_if.aluc),  32'h6);
    tick();
    itype(O_LW, 5, 1);
    check("lw_ctrl", {28'd0, id_if.wreg, id_if.m2reg, id_if.aluimm, id_if.regrt}, 32'hF);
    check("lw_fwda", 32'(id_if.fwda), 32'd0);
    tick();
    rtype(F_ADD, 6, 5, 5);
    check("lu_wpcir", 32'(id_if.wpcir), 32'd0);
    check("lu_wreg",  32'(id_if.wreg),  32'd0);
    tick();
    check("lu_cnt",   32'(id_if.stall_cnt), 32'd1);
    check("lu_fwd",   {30'd0, id_if.fwda} << 2 | 32'(id_if.fwdb), 32'hF);
    check("lu_wpcir2", 32'(id_if.wpcir), 32'd1);
    tick();
    rtype(F_ADD, 0, 1, 2);
    tick();
    rtype(F_OR, 7, 0, 0);
    check("r0_fwd",   {30'd0, id_if.fwda} << 2 | 32'(id_if.fwdb), 32'h0);
    check("r0_wpcir", 32'(id_if.wpcir), 32'd1);
    tick();
    rtype(F_ADD, 2, 1, 1);
    tick();
    rtype(F_XOR, 2, 3, 3);
    check("xor_aluc", 32'(id_if.aluc), 32'h9);
    tick();
    rtype(F_AND, 8, 2, 2);
    check("exwin_fwd", {30'd0, id_if.fwda} << 2 | 32'(id_if.fwdb), 32'h5);
    tick();
    rtype(F_SUB, 9, 10, 11);
    tick();
    rtype(F_OR, 10, 8, 1);
    check("mem_alu_fwda", 32'(id_if.fwda), 32'd2);
    check("mem_alu_fwdb", 32'(id_if.fwdb), 32'd0);
    tick();
    rtype(F_ADD, 12, 1, 1);
    tick();
    itype(O_LW, 12, 1);
    tick();
    rtype(F_ADD, 13, 12, 1);
    check("ldex_wpcir", 32'(id_if.wpcir), 32'd0);
    check("ldex_fwda",  32'(id_if.fwda),  32'd0);
    check("ldex_cnt",   32'(id_if.stall_cnt), 32'd1);
    clrn = 1'b0;
    #1;
    check("rstmid_wpcir", 32'(id_if.wpcir), 32'd1);
    check("rstmid_cnt",   32'(id_if.stall_cnt), 32'd0);
    tick();
    clrn = 1'b1;
`else
    rtype(F_ADD, 3, 1, 2);
    check("add_wreg", 32'(id_if.wreg), 32'd1);
    tick();
    rtype(F_SUB, 4, 3, 1);
    check("dep1_wpcir", 32'(id_if.wpcir), 32'd0);
    check("dep1_wreg",  32'(id_if.wreg),  32'd0);
    check("dep1_fwda",  32'(id_if.fwda),  32'd0);
    tick();
    check("dep2_cnt",   32'(id_if.stall_cnt), 32'd1);
    check("dep2_wpcir", 32'(id_if.wpcir), 32'd0);
    tick();
    check("dep3_wpcir", 32'(id_if.wpcir), 32'd1);
    check("dep3_wreg",  32'(id_if.wreg),  32'd1);
    check("dep3_fwda",  32'(id_if.fwda),  32'd0);
    check("dep3_cnt",   32'(id_if.stall_cnt), 32'd2);
    check("sub_aluc",   32'(id_if.aluc),  32'h6);
    tick();
    rtype(F_ADD, 0, 1, 2);
    tick();
    rtype(F_OR, 7, 0, 0);
    check("r0_wpcir", 32'(id_if.wpcir), 32'd1);
    check("r0_aluc",  32'(id_if.aluc),  32'h1);
    tick();
    itype(O_LW, 5, 1);
    check("lw_ctrl", {28'd0, id_if.wreg, id_if.m2reg, id_if.aluimm, id_if.regrt}, 32'hF);
    tick();
    itype(O_SW, 5, 1);
    check("sw_rt_wpcir", 32'(id_if.wpcir), 32'd0);
    check("sw_rt_wmem",  32'(id_if.wmem),  32'd0);
    clrn = 1'b0;
    #1;
    check("rstmid_wpcir", 32'(id_if.wpcir), 32'd1);
    check("rstmid_cnt",   32'(id_if.stall_cnt), 32'd0);
    check("rstmid_wmem",  32'(id_if.wmem),  32'd1);
    tick();
    clrn = 1'b1;
    tick();
    rtype(F_ADD, 3, 1, 2);
    tick();
    itype(O_ADDI, 3, 1);
    check("addi_rt_unused", 32'(id_if.wpcir), 32'd1);
    check("addi_wreg",      32'(id_if.wreg),  32'd1);
    tick();
`endif

    rtype(F_ADD, 20, 21, 22);
    tick();
    itype(6'b111111, 20, 20);
    check("ill_illegal", 32'(id_if.illegal), 32'd1);
    check("ill_we",      {30'd0, id_if.wreg, id_if.wmem}, 32'd0);
    check("ill_wpcir",   32'(id_if.wpcir), 32'd1);
    rtype(6'b111111, 1, 2, 3);
    check("badfunc_illegal", 32'(id_if.illegal), 32'd1);
    check("badfunc_wreg",    32'(id_if.wreg),    32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
